// File: rtl/ins_rom_loader_pkg.sv
// Shared definitions for the boot-time instruction ROM loader:
// FSM state encodings, default load address and instruction word size.
package ins_rom_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
   localparam int          WORD_BYTES    = 4;

endpackage

// File: rtl/ins_rom_loader_byte_packer.sv
// Collects bytes into little-endian 32-bit words; the first byte of a word lands in [7:0].
// word_next/word_valid present the completed word in the same cycle the 4th byte is accepted.
module ins_byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_valid
);

   logic [1:0]  byte_cnt_q;
   logic [31:0] shift_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= 32'd0;
      end else if (clear) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= 32'd0;
      end else if (byte_en) begin
         byte_cnt_q <= byte_cnt_q + 2'd1;
         shift_q    <= {byte_in, shift_q[31:8]};
      end
   end

   // Newest byte enters at the top, so after four bytes the first one sits in [7:0].
   assign word_next  = {byte_in, shift_q[31:8]};
   assign word_valid = byte_en && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/ins_rom_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes words into instruction ROM,
// then hands the ROM port to the core by raising sel.
module ins_rom_loader
   import ins_rom_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          MAX_WORDS   = 1024,
   parameter int          TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] ins_addr_nap,
   output logic [31:0] ins_data_nap,
   output logic        we_cpu,
   output logic        sel,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int WC_W  = $clog2(MAX_WORDS + 1);
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   state_t            state_q, state_d;
   logic              xfer, start_ok, tmo_hit, enter_done, enter_err;
   logic [31:0]       word_next, wr_off;
   logic              word_valid;
   logic [WC_W-1:0]   n_words_q, wr_cnt_q;
   logic [TMO_W-1:0]  tmo_q;

   assign rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
   assign busy     = rx_ready || (state_q == ST_WRITE);
   assign xfer     = rx_valid && rx_ready;
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign tmo_hit  = (TIMEOUT_CYC != 0) && rx_ready && !xfer &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
   assign wr_off   = 32'(wr_cnt_q) * 32'(WORD_BYTES);

   ins_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_ok),
      .byte_en    (xfer),
      .byte_in    (rx_data),
      .word_next  (word_next),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (start_ok) state_d = ST_LEN;
         ST_LEN: begin
            if (xfer && word_valid) begin
               if (word_next == 32'd0)                 state_d = ST_DONE;
               else if (word_next > 32'(MAX_WORDS))    state_d = ST_ERR;
               else                                    state_d = ST_DATA;
            end else if (tmo_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_DATA: begin
            if (xfer && word_valid) state_d = ST_WRITE;
            else if (tmo_hit)       state_d = ST_ERR;
         end
         ST_WRITE: state_d = (wr_cnt_q == n_words_q) ? ST_DONE : ST_DATA;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
   assign enter_err  = (state_d == ST_ERR)  && (state_q != ST_ERR);

   // Write port is registered on the 4th-byte edge, so we_cpu is high exactly during WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_cpu       <= 1'b0;
         ins_addr_nap <= 32'd0;
         ins_data_nap <= 32'd0;
         sel          <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         n_words_q    <= '0;
         wr_cnt_q     <= '0;
         tmo_q        <= '0;
      end else begin
         we_cpu <= 1'b0;
         if (start_ok) begin
            sel      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_cnt_q <= '0;
         end
         if (enter_done) begin
            sel  <= 1'b1;
            done <= 1'b1;
         end
         if (enter_err) err <= 1'b1;
         if ((state_q == ST_LEN) && xfer && word_valid) n_words_q <= word_next[WC_W-1:0];
         if ((state_q == ST_DATA) && xfer && word_valid) begin
            we_cpu       <= 1'b1;
            ins_addr_nap <= BASE_ADDR + wr_off;
            ins_data_nap <= word_next;
            wr_cnt_q     <= wr_cnt_q + 1'b1;
         end
         if (start_ok || xfer || !rx_ready) tmo_q <= '0;
         else                               tmo_q <= tmo_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_ins_rom_loader.sv
// Directed bench for ins_rom_loader: table of load frames plus timeout, ignored-start
// and mid-session reset sequences.
module tb_ins_rom_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] ins_addr_nap;
   logic [31:0] ins_data_nap;
   logic        we_cpu;
   logic        sel;
   logic        busy;
   logic        done;
   logic        err;

   ins_rom_loader #(
      .BASE_ADDR   (32'h0000_0000),
      .MAX_WORDS   (4),
      .TIMEOUT_CYC (50)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .ins_addr_nap (ins_addr_nap),
      .ins_data_nap (ins_data_nap),
      .we_cpu       (we_cpu),
      .sel          (sel),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       len;
      int                nsend;
      logic [3:0][31:0]  w;
      logic              ok;
      int                nw;
   } vec_t;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int end_cyc;
   logic prev_we = 1'b0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   vec_t        vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else             passed++;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && we_cpu) begin
         wa_q.push_back(ins_addr_nap);
         wd_q.push_back(ins_data_nap);
         wc_q.push_back(cyc);
         chk("rx_ready_in_write", rx_ready, 0);
         chk("we_single_clk", prev_we, 0);
      end
      prev_we = we_cpu;
   end

   task automatic clear_log();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("byte_accepted", rx_ready, 1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 30) begin
         @(negedge clk);
         n++;
      end
      end_cyc = cyc;
   endtask

   task automatic chk_writes(input int n, input logic [3:0][31:0] w);
      chk("write_count", wa_q.size(), n);
      for (int j = 0; j < n; j++) begin
         if (j < wa_q.size()) begin
            chk("write_addr", wa_q[j], 32'(4 * j));
            chk("write_data", wd_q[j], w[j]);
         end
      end
   endtask

   initial begin
      vecs[0] = '{len: 32'd2,     nsend: 2, w: {32'h0, 32'h0, 32'h0010_0093, 32'h0000_0013}, ok: 1'b1, nw: 2};
      vecs[1] = '{len: 32'd0,     nsend: 0, w: '0,                                           ok: 1'b1, nw: 0};
      vecs[2] = '{len: 32'd5,     nsend: 0, w: '0,                                           ok: 1'b0, nw: 0};
      vecs[3] = '{len: 32'd4,     nsend: 4, w: {32'h0, 32'hffff_ffff, 32'h1122_3344, 32'haabb_ccdd}, ok: 1'b1, nw: 4};
      vecs[4] = '{len: 32'h100,   nsend: 0, w: '0,                                           ok: 1'b0, nw: 0};
      vecs[5] = '{len: 32'd1,     nsend: 1, w: {32'h0, 32'h0, 32'h0, 32'h1234_5678},         ok: 1'b1, nw: 1};

      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle_sel", sel, 0);
      chk("idle_we", we_cpu, 0);
      chk("idle_rx_ready", rx_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);

      for (int v = 0; v < 6; v++) begin
         clear_log();
         start_pulse();
         chk("start_busy", busy, 1);
         chk("start_sel", sel, 0);
         chk("start_done", done, 0);
         chk("start_err", err, 0);
         send_word(vecs[v].len);
         for (int j = 0; j < vecs[v].nsend; j++) send_word(vecs[v].w[j]);
         wait_end();
         chk("end_done", done, vecs[v].ok);
         chk("end_err", err, !vecs[v].ok);
         chk("end_sel", sel, vecs[v].ok);
         chk("end_busy", busy, 0);
         chk("end_rx_ready", rx_ready, 0);
         chk_writes(vecs[v].nw, vecs[v].w);
         if (vecs[v].ok && wc_q.size() > 0) chk("done_after_last_write", end_cyc, wc_q[wc_q.size()-1] + 1);
      end

      // Timeout: length 1, two data bytes, then the source goes quiet.
      clear_log();
      start_pulse();
      send_word(32'd1);
      send_byte(8'hab);
      send_byte(8'hcd);
      repeat (49) @(negedge clk);
      chk("tmo_err_before", err, 0);
      chk("tmo_busy_before", busy, 1);
      @(negedge clk);
      chk("tmo_err", err, 1);
      chk("tmo_sel", sel, 0);
      chk("tmo_busy", busy, 0);
      chk("tmo_writes", wa_q.size(), 0);

      // start during DATA must not restart the session.
      clear_log();
      start_pulse();
      send_word(32'd3);
      send_word(32'h0000_1111);
      @(negedge clk);
      start_pulse();
      send_word(32'h0000_2222);
      send_word(32'h0000_3333);
      wait_end();
      chk("ign_done", done, 1);
      chk("ign_sel", sel, 1);
      chk_writes(3, {32'h0, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111});

      // Reset in the middle of DATA, then a clean full load.
      clear_log();
      start_pulse();
      send_word(32'd3);
      send_word(32'hdead_beef);
      send_byte(8'h55);
      rst_n = 1'b0;
      #1;
      chk("rst_sel", sel, 0);
      chk("rst_we", we_cpu, 0);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_data", ins_data_nap, 32'h0);
      chk("rst_addr", ins_addr_nap, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_log();
      start_pulse();
      send_word(32'd3);
      send_word(32'h0102_0304);
      send_word(32'h0506_0708);
      send_word(32'h090a_0b0c);
      wait_end();
      chk("rl_done", done, 1);
      chk("rl_err", err, 0);
      chk("rl_sel", sel, 1);
      chk_writes(3, {32'h0, 32'h090a_0b0c, 32'h0506_0708, 32'h0102_0304});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
